// File: rtl/mpu_pkg.sv
// ============================================================================
// Module      : mpu_pkg
// Description : Shared types and constants for the systolic MPU controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mpu_pkg;

    localparam int N_DEFAULT     = 4;
    localparam int K_MAX_DEFAULT = 16;
    localparam int LOAD_CYCLES   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage : mpu_pkg

`default_nettype wire

// File: rtl/mpu_skew.sv
// ============================================================================
// Module      : mpu_skew
// Description : Diagonal activation skew: lane i is fed vectors t-i while
//               i <= t < i+k, producing the wavefront the systolic array needs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_skew
    import mpu_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int K_MAX = K_MAX_DEFAULT,
    parameter int TW    = $clog2(K_MAX + N)
) (
    input  logic                          active,
    input  logic [TW-1:0]                 t,
    input  logic [$clog2(K_MAX+1)-1:0]    k,
    output logic [N-1:0]                  feed_en,
    output logic [N*$clog2(K_MAX)-1:0]    feed_idx
);

    localparam int IW = $clog2(K_MAX);
    localparam int EW = TW + 1;

    genvar i;
    for (i = 0; i < N; i++) begin : g_lane
        localparam logic [TW-1:0] c_lane   = TW'(i);
        localparam logic [EW-1:0] c_lane_e = EW'(i);

        logic [EW-1:0] w_t_ext;
        logic [EW-1:0] w_end;
        logic [IW-1:0] w_idx;
        logic          w_en;

        // One extra bit keeps i+k from wrapping at the top of the range.
        assign w_t_ext = {1'b0, t};
        assign w_end   = c_lane_e + EW'(k);
        assign w_idx   = IW'(t - c_lane);
        assign w_en    = active && (w_t_ext >= c_lane_e) && (w_t_ext < w_end);

        assign feed_en[i]             = w_en;
        assign feed_idx[i*IW +: IW]   = w_en ? w_idx : '0;
    end

endmodule : mpu_skew

`default_nettype wire

// File: rtl/mpu_ctrl.sv
// ============================================================================
// Module      : mpu_ctrl
// Description : Job sequencer for an N x N int8 systolic array: weight load,
//               skewed activation feed, pipeline drain and completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mpu_ctrl
    import mpu_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int K_MAX = K_MAX_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [$clog2(K_MAX+1)-1:0]    k_len,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic                          arr_rst,
    output logic [N-1:0]                  feed_en,
    output logic [N*$clog2(K_MAX)-1:0]    feed_idx,
    output logic                          res_valid
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int TW = $clog2(K_MAX + N);
    localparam int CW = $clog2(N + LOAD_CYCLES);

    localparam logic [CW-1:0] c_load_last  = CW'(LOAD_CYCLES - 1);
    localparam logic [CW-1:0] c_drain_last = CW'(N - 1);
    localparam logic [TW-1:0] c_skew_span  = TW'(N - 2);
    localparam logic [KW-1:0] c_k_max      = KW'(K_MAX);

    state_t        r_state;
    logic [KW-1:0] r_k;
    logic [TW-1:0] r_t;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_arr_rst;

    logic          w_k_legal;
    logic [TW-1:0] w_t_last;
    logic          w_feeding;

    assign w_k_legal = (k_len != '0) && (k_len <= c_k_max);
    assign w_t_last  = TW'(r_k) + c_skew_span;
    assign w_feeding = (r_state == ST_FEED);

    // All counters stop at their terminal value; the state change there
    // is what moves the job forward, so they never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_k       <= '0;
            r_t       <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_arr_rst <= 1'b0;
        end else begin
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_arr_rst <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_k_legal) begin
                            r_state   <= ST_LOAD;
                            r_k       <= k_len;
                            r_cnt     <= '0;
                            r_t       <= '0;
                            r_busy    <= 1'b1;
                            r_arr_rst <= 1'b0;
                        end else begin
                            r_err     <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_t     <= '0;
                    end else if (r_cnt == c_load_last) begin
                        r_state <= ST_FEED;
                        r_t     <= '0;
                    end else begin
                        r_cnt     <= r_cnt + CW'(1);
                        r_arr_rst <= 1'b0;
                    end
                end
                ST_FEED: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_t     <= '0;
                    end else if (r_t == w_t_last) begin
                        r_state <= ST_DRAIN;
                        r_cnt   <= '0;
                    end else begin
                        r_t     <= r_t + TW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_t     <= '0;
                    end else if (r_cnt == c_drain_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_t     <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_t     <= '0;
                end
            endcase
        end
    end

    mpu_skew #(
        .N     (N),
        .K_MAX (K_MAX),
        .TW    (TW)
    ) u_skew (
        .active   (w_feeding),
        .t        (r_t),
        .k        (r_k),
        .feed_en  (feed_en),
        .feed_idx (feed_idx)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign res_valid = r_done;
    assign err       = r_err;
    assign arr_rst   = r_arr_rst;

endmodule : mpu_ctrl

`default_nettype wire

// File: doc/mpu_ctrl.md
MPU_CTRL -- requirements
Module: mpu_ctrl

Interface
REQ-001 Parameter N, default 4: systolic array dimension (N x N int8 processing elements).
REQ-002 Parameter K_MAX, default 16: maximum number of activation vectors per job.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  job request, sampled in IDLE only.
REQ-006 k_len  in  $clog2(K_MAX+1)  activation vector count; legal range is 1..K_MAX.
REQ-007 abort  in  1  cancels the current job.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse when results are valid.
REQ-010 err  out  1  one-cycle pulse when start is rejected for an illegal k_len.
REQ-011 arr_rst  out  1  active-low array reset; PEs capture weight_in while it is low.
REQ-012 feed_en  out  N  per-row activation-lane enable (skewed).
REQ-013 feed_idx  out  N*$clog2(K_MAX)  per-lane activation vector index; lane i occupies slice i.
REQ-014 res_valid  out  1  accumulator outputs are stable; coincident with done.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, FEED, DRAIN, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-016 In IDLE: start=1 with k_len in 1..K_MAX -> latch k_len, go to LOAD.
REQ-017 In IDLE: start=1 with k_len=0 or k_len>K_MAX -> err=1 for one cycle, stay in IDLE.
REQ-018 start SHALL be ignored outside IDLE; no queuing.
REQ-019 LOAD lasts exactly 2 cycles with arr_rst=0 (weight capture and accumulator clear); arr_rst=1 in all other non-reset states.
REQ-020 FEED lasts k_len+N-1 cycles, driven by counter t = 0..k_len+N-2.
REQ-021 In FEED: feed_en[i]=1 iff i <= t < i+k_len; feed_idx[i]=t-i when enabled, else 0.
REQ-022 DRAIN lasts exactly N cycles with feed_en all zero; then go to DONE.
REQ-023 DONE lasts 1 cycle with done=1 and res_valid=1; then go to IDLE.
REQ-024 Latency: start accepted at edge 0 -> done high in cycle k_len+2N+2 (N=4, k_len=3 -> cycle 13).
REQ-025 abort=1 in LOAD, FEED or DRAIN -> IDLE next cycle; feed_en cleared; no done pulse.
REQ-026 abort in IDLE or DONE SHALL have no effect; in DONE the done pulse still completes.
REQ-027 abort and start in the same cycle in IDLE: start wins, because abort is ignored in IDLE.
REQ-028 Counters SHALL saturate at their terminal values; no wrap is permitted.

Reset
REQ-029 rst low SHALL immediately force state=IDLE, t=0, latched k_len=0, busy=0, done=0, err=0, res_valid=0, feed_en=0, feed_idx=0 and arr_rst=0.
REQ-030 arr_rst SHALL rise to 1 on the first clock edge after rst deasserts.
REQ-031 Reset asserted mid-job SHALL discard the job; no done pulse after reset release.

Structure
REQ-032 Shared package mpu_pkg SHALL hold the state enum, default N, default K_MAX and the LOAD_CYCLES=2 constant.
REQ-033 Skew generation (t, N -> feed_en, feed_idx) SHALL be a sub-module named mpu_skew; the FSM, counters and handshake stay in mpu_ctrl.

Verification
REQ-034 N=4, start with k_len=3 -> arr_rst low in cycles 1-2; feed_en[0] high in cycles 3-5, feed_en[3] high in cycles 6-8; done in cycle 13.
REQ-035 start with k_len=0, then with k_len=17 -> err pulse each time; busy stays 0; arr_rst stays 1.
REQ-036 abort in the 2nd FEED cycle -> IDLE next cycle, feed_en=0, no done; a new start then completes normally.
REQ-037 start pulsed during FEED -> ignored; exactly one done for the job.
REQ-038 rst asserted mid-DRAIN -> all outputs reset asynchronously before the next clk edge; after release, IDLE with arr_rst=1 one edge later.
REQ-039 k_len=K_MAX=16, N=4 -> feed_idx[3] reaches 15 at t=18; done in cycle 26.
